// File: rtl/tank_motion_ctrl.sv
// Per-frame tank controller: HID keycode -> move/rotate, wrapping angle, clamped sub-pixel position.
// Optional firing with cooldown is compiled in when TANK_FIRE_EN is defined.
module tank_motion_ctrl #(
    parameter logic [9:0]         X_CENTER      = 10'd300,
    parameter logic [9:0]         Y_CENTER      = 10'd250,
    parameter int                 X_MIN         = 0,
    parameter int                 X_MAX         = 639,
    parameter int                 Y_MIN         = 0,
    parameter int                 Y_MAX         = 479,
    parameter logic [9:0]         SIZE          = 10'd10,
    parameter logic [7:0]         SPEED         = 8'h20,
    parameter int                 ANGLE_W       = 6,
    parameter logic [ANGLE_W-1:0] ANGLE_INIT    = '0,
    parameter logic [3:0]         ROT_DIV       = 4'd2,
    parameter logic [7:0]         KEY_FWD       = 8'h52,
    parameter logic [7:0]         KEY_BACK      = 8'h51,
    parameter logic [7:0]         KEY_LEFT      = 8'h50,
    parameter logic [7:0]         KEY_RIGHT     = 8'h4F,
    parameter logic [7:0]         KEY_FIRE      = 8'h2C,
    parameter logic [7:0]         FIRE_COOLDOWN = 8'd30
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic [31:0]        keycode,
    input  logic [7:0]         sin,
    input  logic [7:0]         cos,
    output logic [9:0]         TankX,
    output logic [9:0]         TankY,
    output logic [9:0]         TankS,
    output logic [ANGLE_W-1:0] Angle,
    output logic               Moving,
    output logic               Blocked,
    output logic               Fire
);

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_ROTATE} state_e;
    typedef enum logic [2:0] {CMD_NONE, CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT} cmd_e;
    typedef struct packed {
        logic        clamp;
        logic [20:0] pos;
    } axis_t;

    localparam logic signed [12:0] X_LO = 13'(X_MIN + int'(SIZE));
    localparam logic signed [12:0] X_HI = 13'(X_MAX - int'(SIZE));
    localparam logic signed [12:0] Y_LO = 13'(Y_MIN + int'(SIZE));
    localparam logic signed [12:0] Y_HI = 13'(Y_MAX - int'(SIZE));

    function automatic logic key_held(input logic [31:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) || (kc[15:8] == code) ||
               (kc[23:16] == code) || (kc[31:24] == code);
    endfunction

    // Adds (or subtracts) a Q5.11 step to a {int10,frac11} position; the integer part is
    // examined as signed 13 bits so under/overflow past the arena edge cannot wrap.
    function automatic axis_t axis_step(input logic [20:0] pos, input logic signed [15:0] delta,
                                        input logic neg, input logic signed [12:0] lo,
                                        input logic signed [12:0] hi);
        axis_t              res;
        logic signed [23:0] step;
        logic signed [23:0] sum;
        logic signed [12:0] ipart;
        step = {{8{delta[15]}}, delta};
        if (neg) step = -step;
        sum   = $signed({3'b000, pos}) + step;
        ipart = sum[23:11];
        res.clamp = 1'b1;
        if (ipart < lo)      res.pos = {lo[9:0], 11'd0};
        else if (ipart > hi) res.pos = {hi[9:0], 11'd0};
        else begin
            res.clamp = 1'b0;
            res.pos   = sum[20:0];
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [20:0]        pos_x_q, pos_x_d;
    logic [20:0]        pos_y_q, pos_y_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [3:0]         rot_cnt_q, rot_cnt_d;
    logic               blocked_q, blocked_d;
    cmd_e               cmd;
    logic signed [15:0] dx, dy;
    axis_t              x_step, y_step;

    always_comb begin
        if (key_held(keycode, KEY_FWD))        cmd = CMD_FWD;
        else if (key_held(keycode, KEY_BACK))  cmd = CMD_BACK;
        else if (key_held(keycode, KEY_LEFT))  cmd = CMD_LEFT;
        else if (key_held(keycode, KEY_RIGHT)) cmd = CMD_RIGHT;
        else                                   cmd = CMD_NONE;
    end

    // SPEED is unsigned Q4.4, trig is signed Q1.7; the product is signed Q5.11.
    assign dx = $signed({8'h00, SPEED}) * $signed({{8{cos[7]}}, cos});
    assign dy = $signed({8'h00, SPEED}) * $signed({{8{sin[7]}}, sin});

    // Screen Y grows downward, so forward motion subtracts dy.
    assign x_step = axis_step(pos_x_q, dx, cmd == CMD_BACK, X_LO, X_HI);
    assign y_step = axis_step(pos_y_q, dy, cmd == CMD_FWD,  Y_LO, Y_HI);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = ST_IDLE;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        angle_d   = angle_q;
        rot_cnt_d = 4'd0;
        blocked_d = 1'b0;
        unique case (cmd)
            CMD_FWD, CMD_BACK: begin
                state_d   = ST_MOVE;
                pos_x_d   = x_step.pos;
                pos_y_d   = y_step.pos;
                blocked_d = x_step.clamp | y_step.clamp;
            end
            CMD_LEFT, CMD_RIGHT: begin
                state_d = ST_ROTATE;
                if (rot_cnt_q == 4'd0)
                    angle_d = (cmd == CMD_LEFT) ? angle_q + ANGLE_W'(1) : angle_q - ANGLE_W'(1);
                rot_cnt_d = (rot_cnt_q >= ROT_DIV - 4'd1) ? 4'd0 : rot_cnt_q + 4'd1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            pos_x_q   <= {X_CENTER, 11'd0};
            pos_y_q   <= {Y_CENTER, 11'd0};
            angle_q   <= ANGLE_INIT;
            rot_cnt_q <= 4'd0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            angle_q   <= angle_d;
            rot_cnt_q <= rot_cnt_d;
            blocked_q <= blocked_d;
        end
    end

    assign TankX   = pos_x_q[20:11];
    assign TankY   = pos_y_q[20:11];
    assign TankS   = SIZE;
    assign Angle   = angle_q;
    assign Moving  = (state_q == ST_MOVE);
    assign Blocked = blocked_q;

`ifdef TANK_FIRE_EN
    logic [7:0] cooldown_q, cooldown_d;
    logic       fire_q, fire_d;

    // Fire runs beside the motion FSM; holding the key re-fires once the cooldown drains.
    always_comb begin
        fire_d     = 1'b0;
        cooldown_d = cooldown_q;
        if (key_held(keycode, KEY_FIRE) && (cooldown_q == 8'd0)) begin
            fire_d     = 1'b1;
            cooldown_d = FIRE_COOLDOWN;
        end else if (cooldown_q != 8'd0) begin
            cooldown_d = cooldown_q - 8'd1;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cooldown_q <= 8'd0;
            fire_q     <= 1'b0;
        end else begin
            cooldown_q <= cooldown_d;
            fire_q     <= fire_d;
        end
    end

    assign Fire = fire_q;
`else
    logic unused_fire_cfg;
    assign unused_fire_cfg = ^{KEY_FIRE, FIRE_COOLDOWN};
    assign Fire = 1'b0;
`endif

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Scoreboard bench for tank_motion_ctrl: stimulus pushes expected per-frame state,
// a negedge monitor pops and compares; directed hand-computed checks cover the key scenarios.
module tb_tank_motion_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic [31:0] keycode;
    logic [7:0]  sin_v, cos_v;
    logic [9:0]  TankX, TankY, TankS;
    logic [5:0]  Angle;
    logic        Moving, Blocked, Fire;

    tank_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .sin       (sin_v),
        .cos       (cos_v),
        .TankX     (TankX),
        .TankY     (TankY),
        .TankS     (TankS),
        .Angle     (Angle),
        .Moving    (Moving),
        .Blocked   (Blocked),
        .Fire      (Fire)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int due;
        int x;
        int y;
        int ang;
        int mov;
        int blk;
        int fire;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    // Reference state: positions in 1/2048 pixel units.
    int m_x, m_y, m_ang, m_rot, m_cd, m_blk, m_mov, m_fire;

    int exp_ang3[5] = '{1, 1, 2, 2, 3};
    int pulses;

    always @(posedge frame_clk) edge_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit held(input logic [31:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) || (kc[15:8] == code) ||
               (kc[23:16] == code) || (kc[31:24] == code);
    endfunction

    task automatic model_reset();
        m_x = 300 * 2048; m_y = 250 * 2048; m_ang = 0; m_rot = 0;
        m_cd = 0; m_blk = 0; m_mov = 0; m_fire = 0;
    endtask

    task automatic model_step(input logic [31:0] kc, input logic [7:0] s, input logic [7:0] c);
        int dxs, dys, nx, ny, sgn;
        bit fwd, back, left, right;
        fwd   = held(kc, 8'h52);
        back  = held(kc, 8'h51);
        left  = held(kc, 8'h50);
        right = held(kc, 8'h4F);
        dxs   = 32 * int'($signed(c));
        dys   = 32 * int'($signed(s));
        m_blk = 0;
        m_mov = 0;
        if (fwd || back) begin
            m_mov = 1;
            sgn   = fwd ? 1 : -1;
            nx    = m_x + sgn * dxs;
            ny    = m_y - sgn * dys;
            if ((nx >>> 11) < 10)       begin nx = 10 * 2048;  m_blk = 1; end
            else if ((nx >>> 11) > 629) begin nx = 629 * 2048; m_blk = 1; end
            if ((ny >>> 11) < 10)       begin ny = 10 * 2048;  m_blk = 1; end
            else if ((ny >>> 11) > 469) begin ny = 469 * 2048; m_blk = 1; end
            m_x   = nx;
            m_y   = ny;
            m_rot = 0;
        end else if (left || right) begin
            if (m_rot == 0) m_ang = (m_ang + (left ? 1 : 63)) % 64;
            m_rot = (m_rot + 1) % 2;
        end else begin
            m_rot = 0;
        end
`ifdef TANK_FIRE_EN
        if (held(kc, 8'h2C) && m_cd == 0) begin
            m_fire = 1;
            m_cd   = 30;
        end else begin
            m_fire = 0;
            if (m_cd > 0) m_cd--;
        end
`else
        m_fire = 0;
`endif
    endtask

    task automatic frame(input logic [31:0] kc, input logic [7:0] s, input logic [7:0] c);
        keycode = kc;
        sin_v   = s;
        cos_v   = c;
        model_step(kc, s, c);
        sb_q.push_back('{edge_cnt + 1, m_x, m_y, m_ang, m_mov, m_blk, m_fire});
        @(posedge frame_clk);
        #1;
    endtask

    always @(negedge frame_clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
            mon_e = sb_q.pop_front();
            check("sb TankX",   int'(TankX),   mon_e.x >>> 11);
            check("sb TankY",   int'(TankY),   mon_e.y >>> 11);
            check("sb Angle",   int'(Angle),   mon_e.ang);
            check("sb Moving",  int'(Moving),  mon_e.mov);
            check("sb Blocked", int'(Blocked), mon_e.blk);
            check("sb Fire",    int'(Fire),    mon_e.fire);
            check("sb TankS",   int'(TankS),   10);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        keycode = 32'h0;
        sin_v   = 8'h00;
        cos_v   = 8'h00;
        model_reset();

        // 1: reset values, then idle frames hold them
        #12;
        check("t1 reset TankX", int'(TankX), 300);
        check("t1 reset TankY", int'(TankY), 250);
        check("t1 reset Angle", int'(Angle), 0);
        check("t1 reset Moving", int'(Moving), 0);
        check("t1 reset Blocked", int'(Blocked), 0);
        check("t1 reset Fire", int'(Fire), 0);
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) frame(32'h0, 8'h00, 8'h00);
        check("t1 idle TankX", int'(TankX), 300);
        check("t1 idle TankY", int'(TankY), 250);

        // 2: forward at angle 0 with a near-unity cosine
        frame(32'h0000_0052, 8'h00, 8'h7F);
        check("t2 f1 TankX", int'(TankX), 301);
        check("t2 f1 frac", int'(dut.pos_x_q[10:0]), 2016);
        check("t2 f1 Moving", int'(Moving), 1);
        frame(32'h0000_0052, 8'h00, 8'h7F);
        check("t2 f2 TankX", int'(TankX), 303);
        check("t2 f2 TankY", int'(TankY), 250);

        // 3: rotate left with divider, then re-press steps immediately
        frame(32'h0, 8'h00, 8'h00);
        check("t3 idle Moving", int'(Moving), 0);
        for (int i = 0; i < 5; i++) begin
            frame(32'h5000_0000, 8'h00, 8'h00);
            check("t3 hold Angle", int'(Angle), exp_ang3[i]);
        end
        frame(32'h0, 8'h00, 8'h00);
        frame(32'h5000_0000, 8'h00, 8'h00);
        check("t3 repress Angle", int'(Angle), 4);

        // 4: wrap both directions
        for (int i = 0; i < 4; i++) begin
            frame(32'h0, 8'h00, 8'h00);
            frame(32'h0000_004F, 8'h00, 8'h00);
        end
        check("t4 back to 0", int'(Angle), 0);
        frame(32'h0, 8'h00, 8'h00);
        frame(32'h0000_004F, 8'h00, 8'h00);
        check("t4 wrap down", int'(Angle), 63);
        frame(32'h0, 8'h00, 8'h00);
        frame(32'h0000_0050, 8'h00, 8'h00);
        check("t4 wrap up", int'(Angle), 0);

        // 5: drive to X=627, then clamp at 629 while Y still moves
        for (int k = 0; k < 400 && (m_x >>> 11) < 627; k++)
            frame(32'h0000_0052, 8'h00, ((m_x >>> 11) < 625) ? 8'h7F : 8'h08);
        check("t5 at 627", int'(TankX), 627);
        frame(32'h0000_0052, 8'h40, 8'h7F);
        frame(32'h0000_0052, 8'h40, 8'h7F);
        check("t5 clamp TankX", int'(TankX), 629);
        check("t5 clamp Blocked", int'(Blocked), 1);
        check("t5 slide TankY", int'(TankY), 248);
        frame(32'h0, 8'h00, 8'h00);
        check("t5 release Blocked", int'(Blocked), 0);
        for (int k = 0; k < 125; k++) frame(32'h0000_0051, 8'h80, 8'h00);
        check("t5 ymin TankY", int'(TankY), 10);
        check("t5 ymin Blocked", int'(Blocked), 1);
        check("t5 ymin TankX", int'(TankX), 629);

        // 6: all keys at once -> forward only; async reset mid-move
        frame(32'h5251_5000, 8'h00, 8'h81);
        check("t6 prio Angle", int'(Angle), 0);
        check("t6 prio Moving", int'(Moving), 1);
        check("t6 prio TankX", int'(TankX), 627);
        keycode = 32'h0000_0052;
        @(negedge frame_clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("t6 async TankX", int'(TankX), 300);
        check("t6 async TankY", int'(TankY), 250);
        check("t6 async Angle", int'(Angle), 0);
        check("t6 async Moving", int'(Moving), 0);
        check("t6 async Blocked", int'(Blocked), 0);
        model_reset();
        #1;
        Reset_n = 1'b1;
        frame(32'h0, 8'h00, 8'h00);

        // 7: held fire key
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            frame(32'h0000_002C, 8'h00, 8'h00);
            pulses += int'(Fire);
`ifdef TANK_FIRE_EN
            check("t7 Fire", int'(Fire), (i % 31 == 0) ? 1 : 0);
`else
            check("t7 Fire", int'(Fire), 0);
`endif
        end
`ifdef TANK_FIRE_EN
        check("t7 pulse count", pulses, 3);
`else
        check("t7 pulse count", pulses, 0);
`endif

        @(negedge frame_clk);
        #1;
        check("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
